board_encoder: RTL and testbench

BOARD_ENCODER -- requirements
Module: board_encoder

---
 rtl/board_proto_pkg.sv | 54 +++++
 rtl/board_encoder_if.sv | 36 +++
 rtl/msg_byte_tx.sv | 46 ++++
 rtl/board_encoder.sv | 190 +++++++++++++++++++
 tb/tb_board_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_proto_pkg.sv
// Shared protocol definitions for the board encoder: message flags, command codes,
// FSM states and the message/bit-selection helpers.
package board_proto_pkg;

  localparam logic [2:0] FlagStartBoard = 3'b111;
  localparam logic [2:0] FlagStartLine  = 3'b110;
  localparam logic [2:0] FlagAnd        = 3'b101;
  localparam logic [2:0] FlagOr         = 3'b010;
  localparam logic [2:0] FlagEndLine    = 3'b001;
  localparam logic [2:0] FlagEndBoard   = 3'b000;

  localparam logic [2:0] CmdBoard  = 3'd0;
  localparam logic [2:0] CmdLine   = 3'd1;
  localparam logic [2:0] CmdOption = 3'd2;
  localparam logic [2:0] CmdEnd    = 3'd3;

  localparam int unsigned MaxOptionCells = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHdrM,
    StHdrN,
    StLine,
    StBits,
    StSep,
    StEndb
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } bit_pick_t;

  // Returns {byte0, byte1} for one two-byte message.
  function automatic logic [15:0] make_msg(input logic [2:0] flag, input logic [11:0] payload,
                                           input logic bit0);
    return {flag, payload[11:7], payload[6:0], bit0};
  endfunction

  // Lowest cell index >= from and < len that needs an AND message.
  function automatic bit_pick_t pick_bit(input logic [15:0] option, input logic [4:0] len,
                                         input logic [4:0] from, input logic sparse);
    bit_pick_t pick;
    pick = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i >= int'(from) && i < int'(len) && (option[i] || !sparse)) begin
        pick.found = 1'b1;
        pick.idx   = 4'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/board_encoder_if.sv
// Command and byte-stream bundle of the board encoder; slave is the encoder side.
interface board_encoder_if #(
  parameter int unsigned MAX_ROWS        = 11,
  parameter int unsigned MAX_COLS        = 11,
  parameter int unsigned MAX_NUM_OPTIONS = 84
);
  localparam int unsigned LinesW = $clog2(MAX_ROWS + MAX_COLS);
  localparam int unsigned OptsW  = $clog2(MAX_NUM_OPTIONS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_type;
  logic [11:0]       cmd_m;
  logic [11:0]       cmd_n;
  logic [15:0]       cmd_option;
  logic [4:0]        cmd_len;
  logic              cmd_last;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;
  logic [LinesW-1:0] lines_sent;
  logic [OptsW-1:0]  options_sent;
  logic              cmd_err;

  modport slave (
    input  cmd_valid, cmd_type, cmd_m, cmd_n, cmd_option, cmd_len, cmd_last, byte_ready,
    output cmd_ready, byte_out, byte_valid, busy, lines_sent, options_sent, cmd_err
  );

  modport master (
    output cmd_valid, cmd_type, cmd_m, cmd_n, cmd_option, cmd_len, cmd_last, byte_ready,
    input  cmd_ready, byte_out, byte_valid, busy, lines_sent, options_sent, cmd_err
  );

endinterface

// File: rtl/msg_byte_tx.sv
// Serialises one two-byte message onto a valid/ready byte stream, holding byte_out while
// stalled; done flags the transfer of byte1 so the next message can load with no bubble.
module msg_byte_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] msg,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        done
);

  logic       byte_sel_q;
  logic       valid_q;
  logic [7:0] byte_out_q;
  logic [7:0] byte1_q;

  assign done       = valid_q && byte_ready && byte_sel_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = valid_q;

  // load is only raised while idle or on the byte1 transfer, so it may take priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      byte_out_q <= '0;
      byte1_q    <= '0;
    end else if (load) begin
      byte_out_q <= msg[15:8];
      byte1_q    <= msg[7:0];
      byte_sel_q <= 1'b0;
      valid_q    <= 1'b1;
    end else if (valid_q && byte_ready) begin
      if (!byte_sel_q) begin
        byte_out_q <= byte1_q;
        byte_sel_q <= 1'b1;
      end else begin
        byte_sel_q <= 1'b0;
        valid_q    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/board_encoder.sv
// Board encoder: turns BOARD/LINE/OPTION/END commands into two-byte protocol messages.
// Define BOARD_ENCODER_SPARSE_EN to skip AND messages for zero cells.
module board_encoder
  import board_proto_pkg::*;
#(
  parameter int unsigned MAX_ROWS        = 11,
  parameter int unsigned MAX_COLS        = 11,
  parameter int unsigned MAX_NUM_OPTIONS = 84
) (
  input logic            clk,
  input logic            rst,
  board_encoder_if.slave bus
);

  localparam int unsigned LinesW = $clog2(MAX_ROWS + MAX_COLS);
  localparam int unsigned OptsW  = $clog2(MAX_NUM_OPTIONS);

`ifdef BOARD_ENCODER_SPARSE_EN
  localparam logic SparseEn = 1'b1;
`else
  localparam logic SparseEn = 1'b0;
`endif

  state_e            state_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              cmd_err_q;
  logic              line_open_q;
  logic              last_q;
  logic [11:0]       n_q;
  logic [15:0]       option_q;
  logic [4:0]        len_q;
  logic [3:0]        idx_q;
  logic [LinesW-1:0] lines_q;
  logic [OptsW-1:0]  opts_q;

  logic        accept;
  logic        illegal;
  logic        load;
  logic        done;
  logic [15:0] msg;
  bit_pick_t   first_pick;
  bit_pick_t   next_pick;

  assign accept  = (state_q == StIdle) && cmd_ready_q && bus.cmd_valid;
  assign illegal = (bus.cmd_type > CmdEnd) ||
                   (bus.cmd_type == CmdOption &&
                    (bus.cmd_len > 5'(MaxOptionCells) || !line_open_q)) ||
                   (bus.cmd_type == CmdLine && line_open_q);

  assign first_pick = pick_bit(bus.cmd_option, bus.cmd_len, 5'd0, SparseEn);
  assign next_pick  = pick_bit(option_q, len_q, 5'(idx_q) + 5'd1, SparseEn);

  // The first message is taken straight from the command bus so it is valid next cycle.
  always_comb begin
    load = 1'b0;
    msg  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && !illegal) begin
          load = 1'b1;
          case (bus.cmd_type)
            CmdBoard:  msg = make_msg(FlagStartBoard, bus.cmd_m, 1'b0);
            CmdLine:   msg = make_msg(FlagStartLine, 12'd0, 1'b0);
            CmdOption: msg = first_pick.found ?
                             make_msg(FlagAnd, 12'(first_pick.idx),
                                      bus.cmd_option[first_pick.idx]) :
                             make_msg(bus.cmd_last ? FlagEndLine : FlagOr, 12'd0, 1'b0);
            default:   msg = make_msg(FlagEndBoard, 12'd0, 1'b0);
          endcase
        end
      end
      StHdrM: begin
        load = done;
        msg  = make_msg(FlagStartBoard, n_q, 1'b0);
      end
      StBits: begin
        load = done;
        msg  = next_pick.found ?
               make_msg(FlagAnd, 12'(next_pick.idx), option_q[next_pick.idx]) :
               make_msg(last_q ? FlagEndLine : FlagOr, 12'd0, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      line_open_q <= 1'b0;
      last_q      <= 1'b0;
      n_q         <= '0;
      option_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      lines_q     <= '0;
      opts_q      <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            if (illegal) begin
              cmd_err_q <= 1'b1;
            end else begin
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              n_q         <= bus.cmd_n;
              option_q    <= bus.cmd_option;
              len_q       <= bus.cmd_len;
              last_q      <= bus.cmd_last;
              // A new board or the end of a board both leave no line open.
              case (bus.cmd_type)
                CmdBoard: begin
                  state_q     <= StHdrM;
                  lines_q     <= '0;
                  opts_q      <= '0;
                  line_open_q <= 1'b0;
                end
                CmdLine: begin
                  state_q     <= StLine;
                  opts_q      <= '0;
                  line_open_q <= 1'b1;
                end
                CmdOption: begin
                  state_q <= first_pick.found ? StBits : StSep;
                  idx_q   <= first_pick.idx;
                end
                default: begin
                  state_q     <= StEndb;
                  line_open_q <= 1'b0;
                end
              endcase
            end
          end
        end
        StHdrM: begin
          if (done) state_q <= StHdrN;
        end
        StBits: begin
          if (done) begin
            if (next_pick.found) idx_q <= next_pick.idx;
            else state_q <= StSep;
          end
        end
        StSep: begin
          if (done) begin
            if (opts_q != '1) opts_q <= opts_q + OptsW'(1);
            if (last_q) begin
              if (lines_q != '1) lines_q <= lines_q + LinesW'(1);
              line_open_q <= 1'b0;
            end
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          if (done) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  msg_byte_tx u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .msg        (msg),
    .byte_ready (bus.byte_ready),
    .byte_out   (bus.byte_out),
    .byte_valid (bus.byte_valid),
    .done       (done)
  );

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.cmd_err      = cmd_err_q;
  assign bus.lines_sent   = lines_q;
  assign bus.options_sent = opts_q;

endmodule

// File: tb/tb_board_encoder.sv
// Scoreboard bench for board_encoder: a message-level model queues expected bytes and a
// monitor pops them as the DUT streams them out.
module tb_board_encoder;

  localparam int unsigned MaxRows = 11;
  localparam int unsigned MaxCols = 11;
  localparam int unsigned MaxOpts = 84;
  localparam int LinesMax = (1 << $clog2(MaxRows + MaxCols)) - 1;
  localparam int OptsMax  = (1 << $clog2(MaxOpts)) - 1;

`ifdef BOARD_ENCODER_SPARSE_EN
  localparam bit Sparse = 1'b1;
`else
  localparam bit Sparse = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  board_encoder_if #(
    .MAX_ROWS        (MaxRows),
    .MAX_COLS        (MaxCols),
    .MAX_NUM_OPTIONS (MaxOpts)
  ) bus ();

  board_encoder #(
    .MAX_ROWS        (MaxRows),
    .MAX_COLS        (MaxCols),
    .MAX_NUM_OPTIONS (MaxOpts)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int  m_lines = 0;
  int  m_opts  = 0;
  bit  m_open  = 1'b0;
  bit  rand_ready_en = 1'b0;
  int  force_stall = 0;
  bit  stall_arm = 1'b0;
  int  stall_at = 0;
  int  popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input int flag, input int payload, input int b);
    exp_q.push_back(8'(flag * 32 + payload / 128));
    exp_q.push_back(8'((payload % 128) * 2 + b));
  endtask

  // Message-level reference: bytes for one command plus the counters it leaves behind.
  task automatic model_cmd(input int t, input int m, input int n, input int opt, input int len,
                           input int last, output bit ill);
    ill = (t > 3) || (t == 2 && (len > 16 || !m_open)) || (t == 1 && m_open);
    if (ill) return;
    case (t)
      0: begin
        push_msg(7, m, 0);
        push_msg(7, n, 0);
        m_lines = 0;
        m_opts  = 0;
        m_open  = 1'b0;
      end
      1: begin
        push_msg(6, 0, 0);
        m_opts = 0;
        m_open = 1'b1;
      end
      2: begin
        for (int i = 0; i < len; i++) begin
          if (!Sparse || ((opt >> i) & 1) == 1) push_msg(5, i, (opt >> i) & 1);
        end
        push_msg(last != 0 ? 1 : 2, 0, 0);
        if (m_opts < OptsMax) m_opts++;
        if (last != 0) begin
          if (m_lines < LinesMax) m_lines++;
          m_open = 1'b0;
        end
      end
      default: begin
        push_msg(0, 0, 0);
        m_open = 1'b0;
      end
    endcase
  endtask

  task automatic run_cmd(input int t, input int m, input int n, input int opt, input int len,
                         input int last, input bit wait_done);
    bit ill;
    int cyc;
    model_cmd(t, m, n, opt, len, last, ill);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_type   = 3'(t);
    bus.cmd_m      = 12'(m);
    bus.cmd_n      = 12'(n);
    bus.cmd_option = 16'(opt);
    bus.cmd_len    = 5'(len);
    bus.cmd_last   = 1'(last);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cmd_ready && cyc < 200);
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept: cmd_ready still %0b after %0d cycles", bus.cmd_ready, cyc);
      bus.cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the fields: the DUT must have captured them already.
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = 3'($urandom);
    bus.cmd_m      = 12'($urandom);
    bus.cmd_n      = 12'($urandom);
    bus.cmd_option = 16'($urandom);
    bus.cmd_len    = 5'($urandom);
    bus.cmd_last   = 1'($urandom);
    @(negedge clk);
    check("cmd_err_pulse", 32'(bus.cmd_err), 32'(ill));
    check("first_byte_latency", 32'(bus.byte_valid), 32'(!ill));
    if (ill) begin
      @(negedge clk);
      check("cmd_err_one_cycle", 32'(bus.cmd_err), 32'd0);
      check("illegal_no_bytes", 32'(bus.byte_valid), 32'd0);
    end
    if (!wait_done) return;
    cyc = 0;
    while ((bus.busy || exp_q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      checks++;
      failures++;
      $display("FAIL cmd_complete: %0d bytes still expected, busy=%0b", exp_q.size(), bus.busy);
      exp_q.delete();
    end
    check("lines_sent", 32'(bus.lines_sent), 32'(m_lines));
    check("options_sent", 32'(bus.options_sent), 32'(m_opts));
  endtask

  initial begin : ready_drv
    bus.byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && popped == stall_at) begin
        force_stall = 5;
        stall_arm   = 1'b0;
      end
      if (force_stall > 0) begin
        bus.byte_ready = 1'b0;
        force_stall--;
      end else if (rand_ready_en) begin
        bus.byte_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.byte_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [7:0] held;
    logic [7:0] e;
    bit hold;
    bit want_ready;
    hold = 1'b0;
    want_ready = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
        want_ready = 1'b0;
      end else begin
        if (want_ready) begin
          check("ready_after_last_byte", 32'(bus.cmd_ready), 32'd1);
          want_ready = 1'b0;
        end
        if (hold) begin
          check("stall_valid_held", 32'(bus.byte_valid), 32'd1);
          check("stall_byte_held", 32'(bus.byte_out), 32'(held));
        end
        if (bus.busy) check("no_bubble", 32'(bus.byte_valid), 32'd1);
        hold = 1'b0;
        if (bus.byte_valid && !bus.byte_ready) begin
          hold = 1'b1;
          held = bus.byte_out;
        end
        if (bus.byte_valid && bus.byte_ready) begin
          popped++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", bus.byte_out);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", 32'(bus.byte_out), 32'(e));
            if (exp_q.size() == 0) want_ready = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    int t;
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = '0;
    bus.cmd_m      = '0;
    bus.cmd_n      = '0;
    bus.cmd_option = '0;
    bus.cmd_len    = '0;
    bus.cmd_last   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_byte_out", 32'(bus.byte_out), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_lines", 32'(bus.lines_sent), 32'd0);
    check("rst_opts", 32'(bus.options_sent), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // Directed examples, with a 5-cycle byte_ready stall inside the BOARD stream.
    stall_arm = 1'b1;
    stall_at  = popped + 2;
    run_cmd(0, 3, 5, 0, 0, 0, 1'b1);
    run_cmd(1, 0, 0, 0, 0, 0, 1'b1);
    run_cmd(2, 0, 0, 'h0005, 3, 0, 1'b1);
    run_cmd(2, 0, 0, 'h0001, 1, 1, 1'b1);
    run_cmd(3, 0, 0, 0, 0, 0, 1'b1);

    // Illegal commands.
    run_cmd(2, 0, 0, 'h0003, 3, 0, 1'b1);
    run_cmd(1, 0, 0, 0, 0, 0, 1'b1);
    run_cmd(2, 0, 0, 'h1FFFF, 17, 0, 1'b1);
    run_cmd(1, 0, 0, 0, 0, 0, 1'b1);
    run_cmd(6, 0, 0, 0, 0, 0, 1'b1);

    // Reset while byte1 of the first AND message is on the bus.
    run_cmd(2, 0, 0, 'h00FF, 8, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_mid_byte_out", 32'(bus.byte_out), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_opts", 32'(bus.options_sent), 32'd0);
    exp_q.delete();
    m_open  = 1'b0;
    m_lines = 0;
    m_opts  = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_mid_release", 32'(bus.cmd_ready), 32'd1);
    run_cmd(1, 0, 0, 0, 0, 0, 1'b1);

    // Counter saturation.
    run_cmd(0, 1, 1, 0, 0, 0, 1'b1);
    for (int i = 0; i < LinesMax + 4; i++) begin
      run_cmd(1, 0, 0, 0, 0, 0, 1'b1);
      run_cmd(2, 0, 0, 0, 0, 1, 1'b1);
    end
    run_cmd(1, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < OptsMax + 3; i++) run_cmd(2, 0, 0, 0, 0, 0, 1'b1);

    // Random commands with random byte_ready back-pressure.
    rand_ready_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) t = 0;
      else if (r < 25) t = 1;
      else if (r < 80) t = 2;
      else if (r < 88) t = 3;
      else t = $urandom_range(4, 7);
      if (t == 2) begin
        run_cmd(2, 0, 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 17)),
                int'($urandom_range(0, 1)), 1'b1);
      end else begin
        run_cmd(t, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0, 0, 0,
                1'b1);
      end
    end
    rand_ready_en = 1'b0;

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
